// File: rtl/arb_pkg.sv
// Shared types and constants for the IF/LS memory bus arbiter.
package arb_pkg;

   localparam int ARB_AW = 64;
   localparam int ARB_DW = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RSP  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/arb_prio_sel.sv
// Purpose: combinational IF/LS priority pick; LS wins unless IF is owed a grant after starvation.
// Latency: zero (pure combinational).
// Backpressure: a flushing IF never wins, and it no longer displaces LS.
module arb_prio_sel (
   input  logic if_req_valid,
   input  logic ls_req_valid,
   input  logic starve_at_limit,
   input  logic if_flush,
   output logic grant_if,
   output logic grant_ls
);

   logic if_forced;

   always_comb begin
      if_forced = starve_at_limit & if_req_valid & ~if_flush;
      grant_ls  = ls_req_valid & ~if_forced;
      grant_if  = if_req_valid & ~if_flush & ~grant_ls;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one single-outstanding bus port between IF and LS; ARB_TIMEOUT_EN adds a response watchdog.
// Latency: accept to rsp_valid is 3 cycles on a zero-wait bus; at most one transaction per 4 cycles.
// Backpressure: only the winner sees *_req_ready, only in IDLE; the bus request is held until bus_req_ready.
module mem_bus_arbiter
   import arb_pkg::*;
#(
   parameter int AW           = ARB_AW,
   parameter int DW           = ARB_DW,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req_valid,
   output logic            if_req_ready,
   input  logic [AW-1:0]   if_addr,
   input  logic            if_flush,
   output logic            if_rsp_valid,
   output logic [DW-1:0]   if_rsp_rdata,
   input  logic            ls_req_valid,
   output logic            ls_req_ready,
   input  logic [AW-1:0]   ls_addr,
   input  logic            ls_wen,
   input  logic [DW-1:0]   ls_wdata,
   input  logic [DW/8-1:0] ls_wmask,
   output logic            ls_rsp_valid,
   output logic [DW-1:0]   ls_rsp_rdata,
   output logic            bus_req_valid,
   input  logic            bus_req_ready,
   output logic [AW-1:0]   bus_addr,
   output logic            bus_wen,
   output logic [DW-1:0]   bus_wdata,
   output logic [DW/8-1:0] bus_wmask,
   input  logic            bus_rsp_valid,
   input  logic [DW-1:0]   bus_rsp_rdata,
   output logic            busy,
   output logic            err
);

   localparam int MW = DW / 8;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_e    state_q, state_d;
   arb_owner_e    owner_q, owner_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          wen_q, wen_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [MW-1:0] wmask_q, wmask_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic          flush_pend_q, flush_pend_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] ls_rdata_q, ls_rdata_d;

   logic grant_if, grant_ls;
   logic starve_at_limit;
   logic tmo_fire;

   assign starve_at_limit = (starve_cnt_q == SW'(STARVE_LIMIT));

   arb_prio_sel u_prio_sel (
      .if_req_valid    (if_req_valid),
      .ls_req_valid    (ls_req_valid),
      .starve_at_limit (starve_at_limit),
      .if_flush        (if_flush),
      .grant_if        (grant_if),
      .grant_ls        (grant_ls)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_err_q, tmo_err_d;

   // Counter restarts every time the bus handshake moves us into WAIT.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      tmo_fire  = 1'b0;
      if (state_q == REQ) begin
         tmo_cnt_d = '0;
      end else if (state_q == WAIT) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
         tmo_fire  = !bus_rsp_valid && (tmo_cnt_q == TW'(TIMEOUT - 1));
      end
      tmo_err_d = tmo_fire;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign err = (state_q == RSP) && tmo_err_q;
`else
   logic tmo_cfg_unused;

   assign tmo_cfg_unused = (TIMEOUT == 0);
   assign tmo_fire       = 1'b0;
   assign err            = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      starve_cnt_d = starve_cnt_q;
      flush_pend_d = flush_pend_q;
      if_rdata_d   = if_rdata_q;
      ls_rdata_d   = ls_rdata_q;

      unique case (state_q)
         IDLE: begin
            flush_pend_d = 1'b0;
            if (grant_if || !if_req_valid) begin
               starve_cnt_d = '0;
            end else if (grant_ls && !starve_at_limit) begin
               starve_cnt_d = starve_cnt_q + 1'b1;
            end
            if (grant_if) begin
               owner_d = OWN_IF;
               addr_d  = if_addr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
               state_d = REQ;
            end else if (grant_ls) begin
               owner_d = OWN_LS;
               addr_d  = ls_addr;
               wen_d   = ls_wen;
               wdata_d = ls_wdata;
               wmask_d = ls_wmask;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus_req_ready) state_d = WAIT;
         end
         WAIT: begin
            // A watchdog expiry returns zero data through the normal response path.
            if (bus_rsp_valid || tmo_fire) begin
               state_d = RSP;
               if (owner_q == OWN_IF) if_rdata_d = bus_rsp_valid ? bus_rsp_rdata : '0;
               else                   ls_rdata_d = bus_rsp_valid ? bus_rsp_rdata : '0;
            end
         end
         RSP: begin
            state_d      = IDLE;
            flush_pend_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      if ((state_q == REQ || state_q == WAIT) && owner_q == OWN_IF && if_flush) begin
         flush_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IF;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         starve_cnt_q <= '0;
         flush_pend_q <= 1'b0;
         if_rdata_q   <= '0;
         ls_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         starve_cnt_q <= starve_cnt_d;
         flush_pend_q <= flush_pend_d;
         if_rdata_q   <= if_rdata_d;
         ls_rdata_q   <= ls_rdata_d;
      end
   end

   // Readies are gated by reset so nothing is accepted while the block is held in reset.
   assign if_req_ready  = rst && (state_q == IDLE) && grant_if;
   assign ls_req_ready  = rst && (state_q == IDLE) && grant_ls;
   assign bus_req_valid = (state_q == REQ);
   assign bus_addr      = addr_q;
   assign bus_wen       = wen_q;
   assign bus_wdata     = wdata_q;
   assign bus_wmask     = wmask_q;
   // A flush landing in the RSP cycle itself still suppresses the IF pulse.
   assign if_rsp_valid  = (state_q == RSP) && (owner_q == OWN_IF) && !flush_pend_q && !if_flush;
   assign ls_rsp_valid  = (state_q == RSP) && (owner_q == OWN_LS);
   assign if_rsp_rdata  = if_rdata_q;
   assign ls_rsp_rdata  = ls_rdata_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed stimulus for mem_bus_arbiter against a timestamp-based transaction model.
module tb_mem_bus_arbiter;

   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int LIM = 4;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          if_req_valid = 1'b0, if_req_ready, if_flush = 1'b0, if_rsp_valid;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rsp_rdata;
   logic          ls_req_valid = 1'b0, ls_req_ready, ls_wen = 1'b0, ls_rsp_valid;
   logic [AW-1:0] ls_addr = '0;
   logic [DW-1:0] ls_wdata = '0, ls_rsp_rdata;
   logic [7:0]    ls_wmask = '0;
   logic          bus_req_valid, bus_req_ready = 1'b0, bus_wen, bus_rsp_valid = 1'b0;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata, bus_rsp_rdata = '0;
   logic [7:0]    bus_wmask;
   logic          busy, err;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
      .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
      .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
      .busy(busy), .err(err)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Requester state (a request is held until its ready is seen)
   bit          if_pend = 0, ls_pend = 0, ls_w = 0;
   logic [63:0] if_a = '0, ls_a = '0, ls_wd = '0;
   logic [7:0]  ls_m = '0;

   // Transaction model: one transaction in flight from the cycle after its grant
   // until its response cycle, which is exactly one cycle after the bus response.
   int          cyc = 0;
   bit          m_busy = 0, m_reqout = 0, m_owner_ls = 0, m_flushed = 0, exp_tmo = 0;
   int          m_starve = 0;
   int          rsp_due = -1, exp_rsp_cyc = -1;
   logic [63:0] exp_rdata = '0, x_addr = '0, x_wdata = '0;
   logic        x_wen = 1'b0;
   logic [7:0]  x_wmask = '0;
`ifdef ARB_TIMEOUT_EN
   int          tmo_cyc = -1;
`endif

   // Directed knobs
   bit          force_flush = 0, use_fixed = 0, no_rsp = 0;
   logic [63:0] fixed_rdata = '0;
   int          n_if_rsp = 0, n_ls_rsp = 0, n_if_gnt = 0, n_ls_gnt = 0, n_err = 0;

   task automatic one_cycle(input int p_if, input int p_ls, input int p_fl, input int p_rdy, input int max_d);
      logic        e_gif, e_gls, e_ifr, e_lsr, e_err, force_if, idle;
      logic [63:0] rsp_drv;
      @(posedge clk);
      #1;
      cyc++;
      if (!if_pend && int'($urandom_range(99)) < p_if) begin
         if_pend = 1;
         if_a    = {$urandom, $urandom};
      end
      if (!ls_pend && int'($urandom_range(99)) < p_ls) begin
         ls_pend = 1;
         ls_a    = {$urandom, $urandom};
         ls_w    = 1'($urandom_range(1));
         ls_wd   = {$urandom, $urandom};
         ls_m    = 8'($urandom);
      end
      if_req_valid  = if_pend;
      if_addr       = if_a;
      ls_req_valid  = ls_pend;
      ls_addr       = ls_a;
      ls_wen        = ls_w;
      ls_wdata      = ls_wd;
      ls_wmask      = ls_m;
      if_flush      = force_flush || (int'($urandom_range(99)) < p_fl);
      bus_req_ready = int'($urandom_range(99)) < p_rdy;
      rsp_drv       = use_fixed ? fixed_rdata : {$urandom, $urandom};
      bus_rsp_valid = (cyc == rsp_due);
      bus_rsp_rdata = rsp_drv;
      @(negedge clk);

      idle     = !m_busy;
      force_if = (m_starve == LIM) && if_pend && !if_flush;
      e_gls    = idle && ls_pend && !force_if;
      e_gif    = idle && if_pend && !if_flush && !e_gls;
      if (m_busy && !m_owner_ls && if_flush) m_flushed = 1;
      e_ifr = m_busy && (cyc == exp_rsp_cyc) && !m_owner_ls && !m_flushed;
      e_lsr = m_busy && (cyc == exp_rsp_cyc) && m_owner_ls;
      e_err = m_busy && (cyc == exp_rsp_cyc) && exp_tmo;

      check("if_req_ready", if_req_ready, e_gif);
      check("ls_req_ready", ls_req_ready, e_gls);
      check("busy", busy, m_busy);
      check("bus_req_valid", bus_req_valid, m_reqout);
      if (m_reqout) begin
         check("bus_addr", bus_addr, x_addr);
         check("bus_wen", bus_wen, x_wen);
         check("bus_wmask", bus_wmask, x_wmask);
         if (m_owner_ls) check("bus_wdata", bus_wdata, x_wdata);
      end
      check("if_rsp_valid", if_rsp_valid, e_ifr);
      check("ls_rsp_valid", ls_rsp_valid, e_lsr);
      check("err", err, e_err);
      if (e_ifr) check("if_rsp_rdata", if_rsp_rdata, exp_rdata);
      if (e_lsr) check("ls_rsp_rdata", ls_rsp_rdata, exp_rdata);
      if (if_rsp_valid) n_if_rsp++;
      if (ls_rsp_valid) n_ls_rsp++;
      if (if_req_ready) n_if_gnt++;
      if (ls_req_ready) n_ls_gnt++;
      if (err) n_err++;

      if (m_busy && cyc == exp_rsp_cyc) begin
         m_busy      = 0;
         exp_rsp_cyc = -1;
         exp_tmo     = 0;
      end
      if (cyc == rsp_due) begin
         if (m_busy && !m_reqout && exp_rsp_cyc < 0) begin
            exp_rsp_cyc = cyc + 1;
            exp_rdata   = rsp_drv;
         end
         rsp_due = -1;
      end
`ifdef ARB_TIMEOUT_EN
      if (m_busy && !m_reqout && exp_rsp_cyc < 0 && cyc == tmo_cyc) begin
         exp_rsp_cyc = cyc + 1;
         exp_rdata   = '0;
         exp_tmo     = 1;
      end
`endif
      if (m_reqout && bus_req_ready) begin
         m_reqout = 0;
`ifdef ARB_TIMEOUT_EN
         tmo_cyc = cyc + TMO;
`endif
         if (!no_rsp) rsp_due = cyc + 1 + int'($urandom_range(max_d));
      end
      if (idle) begin
         if (e_gif || !if_pend) m_starve = 0;
         else if (e_gls && m_starve < LIM) m_starve++;
      end
      if (e_gif || e_gls) begin
         m_busy     = 1;
         m_reqout   = 1;
         m_flushed  = 0;
         m_owner_ls = e_gls;
         x_addr     = e_gls ? ls_a : if_a;
         x_wen      = e_gls ? ls_w : 1'b0;
         x_wdata    = ls_wd;
         x_wmask    = e_gls ? ls_m : 8'h00;
         if (e_gls) ls_pend = 0;
         else       if_pend = 0;
      end
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_if_req_ready"}, if_req_ready, 0);
      check({pfx, "_ls_req_ready"}, ls_req_ready, 0);
      check({pfx, "_if_rsp_valid"}, if_rsp_valid, 0);
      check({pfx, "_ls_rsp_valid"}, ls_rsp_valid, 0);
      check({pfx, "_if_rsp_rdata"}, if_rsp_rdata, 0);
      check({pfx, "_ls_rsp_rdata"}, ls_rsp_rdata, 0);
      check({pfx, "_bus_req_valid"}, bus_req_valid, 0);
      check({pfx, "_bus_addr"}, bus_addr, 0);
      check({pfx, "_bus_wen"}, bus_wen, 0);
      check({pfx, "_bus_wdata"}, bus_wdata, 0);
      check({pfx, "_bus_wmask"}, bus_wmask, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_err"}, err, 0);
   endtask

   initial begin
      int n0, g_if0, g_ls0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b1;

      // 1: lone IF read on a zero-wait bus
      use_fixed   = 1;
      fixed_rdata = 64'h0000_0000_0000_0013;
      if_pend     = 1;
      if_a        = 64'h0000_0000_8000_0000;
      repeat (6) one_cycle(0, 0, 0, 100, 0);
      check("t1_if_rsp_count", n_if_rsp, 1);

      // 2: IF and LS together, LS write goes first
      if_pend = 1;
      if_a    = 64'h0000_0000_8000_0040;
      ls_pend = 1;
      ls_a    = 64'h0000_0000_8000_1000;
      ls_w    = 1;
      ls_wd   = 64'h0000_0000_DEAD_BEEF;
      ls_m    = 8'hFF;
      repeat (10) one_cycle(0, 0, 0, 100, 0);
      check("t2_ls_rsp_count", n_ls_rsp, 1);
      check("t2_if_rsp_count", n_if_rsp, 2);

      // 3: both requesters saturated: four LS grants then one forced IF grant, repeating
      g_if0 = n_if_gnt;
      g_ls0 = n_ls_gnt;
      use_fixed = 0;
      repeat (60) one_cycle(100, 100, 0, 100, 0);
      check("t3_if_grants", n_if_gnt - g_if0, 3);
      check("t3_ls_grants", n_ls_gnt - g_ls0, 12);
      repeat (20) one_cycle(0, 0, 0, 100, 0);

      // 4: flush while the IF read waits on the bus, then a normal IF read
      use_fixed   = 1;
      fixed_rdata = 64'h0000_0000_0000_1234;
      n0          = n_if_rsp;
      if_pend     = 1;
      if_a        = 64'h0000_0000_8000_0100;
      repeat (2) one_cycle(0, 0, 0, 100, 2);
      force_flush = 1;
      one_cycle(0, 0, 0, 100, 2);
      force_flush = 0;
      repeat (6) one_cycle(0, 0, 0, 100, 2);
      check("t4_flushed_no_rsp", n_if_rsp, n0);
      if_pend = 1;
      if_a    = 64'h0000_0000_8000_0104;
      repeat (8) one_cycle(0, 0, 0, 100, 2);
      check("t4_next_if_rsp", n_if_rsp, n0 + 1);
      use_fixed = 0;

      // Random mix of requests, flushes, bus stalls and response delays
      repeat (1500) one_cycle(40, 40, 5, 70, 3);
      repeat (30) one_cycle(0, 0, 0, 100, 0);

      // 5: stalled bus keeps the request stable, then reset lands mid-transaction
      ls_pend = 1;
      ls_a    = 64'h0000_0000_8000_2000;
      ls_w    = 1;
      ls_wd   = 64'h0123_4567_89AB_CDEF;
      ls_m    = 8'h0F;
      repeat (12) one_cycle(0, 0, 0, 0, 0);
      check("t5_stall_req_valid", bus_req_valid, 1);
      #2 rst = 1'b0;
      #1 check_outputs_zero("t5_midreset");
      if_req_valid  = 1'b0;
      ls_req_valid  = 1'b0;
      bus_rsp_valid = 1'b0;
      if_pend = 0; ls_pend = 0;
      m_busy = 0; m_reqout = 0; m_starve = 0;
      rsp_due = -1; exp_rsp_cyc = -1; exp_tmo = 0;
      @(negedge clk);
      rst = 1'b1;
      check("t5_idle_after_release", busy, 0);
      // Late bus response while idle must be ignored
      rsp_due = cyc + 2;
      n0 = n_if_rsp + n_ls_rsp;
      repeat (4) one_cycle(0, 0, 0, 100, 0);
      check("t5_stale_rsp_ignored", n_if_rsp + n_ls_rsp, n0);

`ifdef ARB_TIMEOUT_EN
      // 6: bus never answers, watchdog closes the LS read with zero data and err
      no_rsp  = 1;
      n0      = n_ls_rsp;
      ls_pend = 1;
      ls_a    = 64'h0000_0000_8000_3000;
      ls_w    = 0;
      ls_m    = 8'h00;
      repeat (16) one_cycle(0, 0, 0, 100, 0);
      no_rsp = 0;
      check("t6_tmo_ls_rsp", n_ls_rsp, n0 + 1);
      check("t6_tmo_err_count", n_err, 1);
      rsp_due = cyc + 2;
      n0 = n_if_rsp + n_ls_rsp;
      repeat (4) one_cycle(0, 0, 0, 100, 0);
      check("t6_stale_rsp_ignored", n_if_rsp + n_ls_rsp, n0);
`endif

      repeat (300) one_cycle(50, 50, 5, 60, 3);
      repeat (30) one_cycle(0, 0, 0, 100, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
